pe_buffer_arbiter: RTL

Shares one read port of the on-chip feature/weight buffer among the 16 processing elements (PEs) of the fused-block CNN array. Each PE presents a 13-bit buffer address with a request. The block grants one PE per cycle using round-robin priority and drives the single buffer read port. It then routes the returned data back to the granted PE after the fixed memory latency. It sits between the per-PE address controllers and the shared buffer SRAM.

---
 rtl/fused_ctrl_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 58 +++++
 rtl/pe_buffer_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/fused_ctrl_pkg.sv
// Shared constants and payload types for the fused-block control path.
package fused_ctrl_pkg;

   localparam int unsigned N_PE    = 16;
   localparam int unsigned ADDR_W  = 13;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned MEM_LAT = 2;
   localparam int unsigned PE_ID_W = $clog2(N_PE);

   typedef logic [PE_ID_W-1:0] pe_id_t;

   // One slot of the read-return pipeline: which PE owns the data in flight.
   typedef struct packed {
      logic   valid;
      pe_id_t id;
   } inflight_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// rotating pointer, pointer advanced past the winner on each grant.
module rr_arbiter #(
   parameter int unsigned N_PE = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_en,
   input  logic [N_PE-1:0]          i_req,
   output logic [N_PE-1:0]          o_gnt,
   output logic                     o_gnt_valid,
   output logic [$clog2(N_PE)-1:0]  o_gnt_id
);

   localparam int unsigned ID_W = $clog2(N_PE);

   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_id;
   logic [ID_W-1:0] w_next_ptr;
   logic            w_valid;
   logic [N_PE-1:0] w_gnt;
   int unsigned     w_pos;

   // Search upward from r_ptr with wrap; first requester wins.
   always_comb begin
      w_valid = 1'b0;
      w_id    = '0;
      w_pos   = 0;
      w_gnt   = '0;
      if (i_en && !i_reset) begin
         for (int unsigned k = 0; k < N_PE; k++) begin
            w_pos = 32'(r_ptr) + k;
            if (w_pos >= N_PE) w_pos = w_pos - N_PE;
            if (!w_valid && i_req[ID_W'(w_pos)]) begin
               w_valid = 1'b1;
               w_id    = ID_W'(w_pos);
            end
         end
      end
      if (w_valid) w_gnt[w_id] = 1'b1;
   end

   // Pointer lands just past the winner, wrapping at the last PE.
   always_comb begin
      w_next_ptr = (w_id == ID_W'(N_PE - 1)) ? '0 : w_id + 1'b1;
   end

   // Rotation pointer; holds whenever nobody is granted.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)      r_ptr <= '0;
      else if (w_valid) r_ptr <= w_next_ptr;
   end

   assign o_gnt       = w_gnt;
   assign o_gnt_valid = w_valid;
   assign o_gnt_id    = w_id;

endmodule

// File: rtl/pe_buffer_arbiter.sv
// Shares the single buffer read port among the PEs: round-robin grant,
// registered read issue, and a latency-matched pipeline that steers the
// returned data back to the PE that issued the read.
module pe_buffer_arbiter
   import fused_ctrl_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_en,
   input  logic [N_PE-1:0]          i_req,
   input  logic [N_PE*ADDR_W-1:0]   i_req_addr,
   output logic [N_PE-1:0]          o_gnt,
   output logic                     o_mem_en,
   output logic [ADDR_W-1:0]        o_mem_addr,
   input  logic [DATA_W-1:0]        i_mem_rdata,
   output logic [N_PE-1:0]          o_rsp_valid,
   output logic [DATA_W-1:0]        o_rsp_data,
   output logic                     o_busy
);

   logic [N_PE-1:0]   w_gnt;
   logic              w_gnt_valid;
   pe_id_t            w_gnt_id;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_any_inflight;
   inflight_t         w_tail;

   logic              r_mem_en;
   logic [ADDR_W-1:0] r_mem_addr;
   pe_id_t            r_mem_id;
   inflight_t         r_pipe [MEM_LAT];

   rr_arbiter #(
      .N_PE (N_PE)
   ) u_rr_arbiter (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_en        (i_en),
      .i_req       (i_req),
      .o_gnt       (w_gnt),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   // Select the winning PE's address from the flattened address bus.
   always_comb begin
      w_sel_addr = '0;
      for (int unsigned k = 0; k < N_PE; k++) begin
         if (w_gnt[k]) w_sel_addr = i_req_addr[k*ADDR_W +: ADDR_W];
      end
   end

   // Read issue register; address and owner hold when idle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_mem_en   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_id   <= '0;
      end else begin
         r_mem_en <= w_gnt_valid;
         if (w_gnt_valid) begin
            r_mem_addr <= w_sel_addr;
            r_mem_id   <= w_gnt_id;
         end
      end
   end

   // Owner tags trail mem_en by the SRAM latency so the tail lines up with rdata.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned k = 0; k < MEM_LAT; k++) r_pipe[k] <= '0;
      end else begin
         r_pipe[0].valid <= r_mem_en;
         r_pipe[0].id    <= r_mem_id;
         for (int unsigned k = 1; k < MEM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   // Any owner tag still travelling towards its response slot.
   always_comb begin
      w_any_inflight = 1'b0;
      for (int unsigned k = 0; k < MEM_LAT; k++) begin
         w_any_inflight = w_any_inflight | r_pipe[k].valid;
      end
   end

   assign w_tail      = r_pipe[MEM_LAT-1];
   assign o_gnt       = w_gnt;
   assign o_mem_en    = r_mem_en;
   assign o_mem_addr  = r_mem_addr;
   assign o_rsp_valid = w_tail.valid ? (N_PE'(1) << w_tail.id) : '0;
   assign o_rsp_data  = w_tail.valid ? i_mem_rdata : '0;
   assign o_busy      = r_mem_en | w_any_inflight;

endmodule
